// File: rtl/ir_transmitter_sm_if.sv
// Command/handshake bundle between the IR bus register block and the IR transmitter.
interface ir_transmitter_sm_if;
  logic [3:0] COMMAND;
  logic       SEND_PACKET;
  logic       IR_LED;
  logic       BUSY;

  modport master (output COMMAND, output SEND_PACKET, input IR_LED, input BUSY);
  modport slave  (input COMMAND, input SEND_PACKET, output IR_LED, output BUSY);
endinterface

// File: rtl/ir_transmitter_sm.sv
// IR packet transmitter: START/CARSEL header then one burst per command bit on a modulated carrier.
// Build option: define IR_SEND_TIMER_EN to start packets from an internal SEND_PERIOD timer instead of SEND_PACKET.
module ir_transmitter_sm #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned CARRIER_HZ     = 36_000,
  parameter int unsigned START_BURST    = 88,
  parameter int unsigned CARSEL_BURST   = 22,
  parameter int unsigned GAP            = 40,
  parameter int unsigned ASSERT_BURST   = 44,
  parameter int unsigned DEASSERT_BURST = 22,
  parameter int unsigned SEND_PERIOD    = 10_000_000
) (
  input logic              CLK,
  input logic              RESET,
  ir_transmitter_sm_if.slave bus
);

  function automatic int unsigned umax(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  localparam int unsigned HALF    = CLK_FREQ / (2 * CARRIER_HZ);
  localparam int unsigned HALF_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned MAX_LEN = umax(umax(umax(START_BURST, CARSEL_BURST), umax(GAP, ASSERT_BURST)),
                                         DEASSERT_BURST);
  localparam int unsigned LEN_W   = $clog2(MAX_LEN + 1);

  // Reject configurations that would give a zero-length carrier or segment
  if (HALF == 0 || START_BURST == 0 || CARSEL_BURST == 0 || GAP == 0 ||
      ASSERT_BURST == 0 || DEASSERT_BURST == 0 || SEND_PERIOD == 0) begin : g_param_check
    $error("ir_transmitter_sm: HALF, segment lengths and SEND_PERIOD must all be >= 1");
  end

  // Burst states are odd, gaps and IDLE are even
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] G0     = 4'd2;
  localparam logic [3:0] CARSEL = 4'd3;
  localparam logic [3:0] G1     = 4'd4;
  localparam logic [3:0] RIGHT  = 4'd5;
  localparam logic [3:0] G2     = 4'd6;
  localparam logic [3:0] LEFT   = 4'd7;
  localparam logic [3:0] G3     = 4'd8;
  localparam logic [3:0] BACK   = 4'd9;
  localparam logic [3:0] G4     = 4'd10;
  localparam logic [3:0] FWD    = 4'd11;
  localparam logic [3:0] G5     = 4'd12;

  logic [3:0]        state_q, state_d;
  logic [HALF_W-1:0] half_q, half_d;
  logic              phase_q, phase_d;
  logic [LEN_W-1:0]  per_q, per_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [LEN_W-1:0]  seg_len;
  logic              trigger;

`ifdef IR_SEND_TIMER_EN
  localparam int unsigned TMR_W = $clog2(SEND_PERIOD + 1);
  logic [TMR_W-1:0] tmr_q;

  // Free-running period timer; SEND_PACKET is not used in this build
  always_ff @(posedge CLK) begin
    if (RESET)                                 tmr_q <= '0;
    else if (tmr_q == TMR_W'(SEND_PERIOD - 1)) tmr_q <= '0;
    else                                       tmr_q <= tmr_q + TMR_W'(1);
  end

  assign trigger = (tmr_q == TMR_W'(SEND_PERIOD - 1));
`else
  assign trigger = bus.SEND_PACKET;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      half_q     <= '0;
      phase_q    <= 1'b0;
      per_q      <= '0;
      cmd_q      <= '0;
      bus.IR_LED <= 1'b0;
      bus.BUSY   <= 1'b0;
    end else begin
      state_q    <= state_d;
      half_q     <= half_d;
      phase_q    <= phase_d;
      per_q      <= per_d;
      cmd_q      <= cmd_d;
      bus.IR_LED <= state_d[0] & ~phase_d;
      bus.BUSY   <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    half_d  = half_q;
    phase_d = phase_q;
    per_d   = per_q;
    cmd_d   = cmd_q;
    seg_len = LEN_W'(GAP);

    case (state_q)
      START:   seg_len = LEN_W'(START_BURST);
      CARSEL:  seg_len = LEN_W'(CARSEL_BURST);
      RIGHT:   seg_len = cmd_q[0] ? LEN_W'(ASSERT_BURST) : LEN_W'(DEASSERT_BURST);
      LEFT:    seg_len = cmd_q[1] ? LEN_W'(ASSERT_BURST) : LEN_W'(DEASSERT_BURST);
      BACK:    seg_len = cmd_q[2] ? LEN_W'(ASSERT_BURST) : LEN_W'(DEASSERT_BURST);
      FWD:     seg_len = cmd_q[3] ? LEN_W'(ASSERT_BURST) : LEN_W'(DEASSERT_BURST);
      default: seg_len = LEN_W'(GAP);
    endcase

    if (state_q == IDLE) begin
      if (trigger) begin
        state_d = START;
        cmd_d   = bus.COMMAND;
      end
    end else if (half_q == HALF_W'(HALF - 1)) begin
      // Half-period boundary; a full carrier period ends when the low half completes
      half_d  = '0;
      phase_d = ~phase_q;
      if (phase_q) begin
        if (per_q == seg_len - LEN_W'(1)) begin
          per_d   = '0;
          state_d = (state_q == G5) ? IDLE : state_q + 4'd1;
        end else begin
          per_d = per_q + LEN_W'(1);
        end
      end
    end else begin
      half_d = half_q + HALF_W'(1);
    end
  end

endmodule

// File: tb/tb_ir_transmitter_sm.sv
// Directed bench: two transmitter instances (uniform and mixed segment lengths), HALF=2 carrier.
module tb_ir_transmitter_sm;

  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 CLK = ~CLK;

  ir_transmitter_sm_if bus_a ();
  ir_transmitter_sm_if bus_b ();

  // A: every segment one carrier period
  ir_transmitter_sm #(
    .CLK_FREQ(4), .CARRIER_HZ(1), .START_BURST(1), .CARSEL_BURST(1), .GAP(1),
    .ASSERT_BURST(1), .DEASSERT_BURST(1), .SEND_PERIOD(100)
  ) u_dut_a (.CLK(CLK), .RESET(RESET), .bus(bus_a));

  // B: distinct lengths so bit-dependent burst lengths are visible
  ir_transmitter_sm #(
    .CLK_FREQ(4), .CARRIER_HZ(1), .START_BURST(5), .CARSEL_BURST(2), .GAP(1),
    .ASSERT_BURST(3), .DEASSERT_BURST(2), .SEND_PERIOD(100)
  ) u_dut_b (.CLK(CLK), .RESET(RESET), .bus(bus_b));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_send(input int sel, input logic v);
    if (sel == 0) bus_a.SEND_PACKET = v;
    else          bus_b.SEND_PACKET = v;
  endtask

  task automatic set_cmd(input int sel, input logic [3:0] v);
    if (sel == 0) bus_a.COMMAND = v;
    else          bus_b.COMMAND = v;
  endtask

  function automatic logic get_led(input int sel);
    return (sel == 0) ? bus_a.IR_LED : bus_b.IR_LED;
  endfunction

  function automatic logic get_busy(input int sel);
    return (sel == 0) ? bus_a.BUSY : bus_b.BUSY;
  endfunction

  task automatic send_pulse(input int sel);
    set_send(sel, 1'b1);
    step();
    set_send(sel, 1'b0);
  endtask

  task automatic idle_check(input int sel, input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(get_busy(sel)), 32'd0);
      check_eq($sformatf("%s_led[%0d]", tag, i), 32'(get_led(sel)), 32'd0);
      step();
    end
  endtask

  // Called one tick after the accepting edge; checks every packet cycle, ends on the first IDLE cycle
  task automatic packet_body(input int sel, input logic [3:0] cmd, input bit disturb, input string tag);
    int lens[12];
    int total, seg, pos, acc;
    logic exp_led;
    for (int s = 0; s < 12; s++) lens[s] = 1;
    if (sel == 1) begin
      lens[0] = 5;
      lens[2] = 2;
      for (int b = 0; b < 4; b++) lens[4 + 2*b] = cmd[b] ? 3 : 2;
    end
    total = 0;
    for (int s = 0; s < 12; s++) total += lens[s] * 4;
    for (int i = 0; i < total; i++) begin
      acc = 0;
      seg = 0;
      while (i >= acc + lens[seg] * 4) begin
        acc += lens[seg] * 4;
        seg++;
      end
      pos = i - acc;
      exp_led = ((seg % 2) == 0) && ((pos % 4) < 2);
      check_eq($sformatf("%s_busy[%0d]", tag, i), 32'(get_busy(sel)), 32'd1);
      check_eq($sformatf("%s_led[%0d]", tag, i), 32'(get_led(sel)), 32'(exp_led));
      if (disturb && i == 6) begin
        set_send(sel, 1'b1);
        set_cmd(sel, ~cmd);
      end
      if (disturb && i == 7) set_send(sel, 1'b0);
      step();
    end
    check_eq($sformatf("%s_end_busy", tag), 32'(get_busy(sel)), 32'd0);
    check_eq($sformatf("%s_end_led", tag), 32'(get_led(sel)), 32'd0);
  endtask

  initial begin
    bus_a.COMMAND = 4'd0;
    bus_a.SEND_PACKET = 1'b0;
    bus_b.COMMAND = 4'd0;
    bus_b.SEND_PACKET = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    RESET = 1'b0;
    idle_check(0, 3, "rst_a");
    idle_check(1, 2, "rst_b");

    // Uniform lengths, 1010: 48 busy cycles of 1100/0000 groups
    set_cmd(0, 4'b1010);
    send_pulse(0);
    packet_body(0, 4'b1010, 1'b0, "a1010");
    idle_check(0, 2, "a1010_post");

    // Mixed lengths: only set bits get the long burst
    set_cmd(1, 4'b0001);
    send_pulse(1);
    packet_body(1, 4'b0001, 1'b0, "b0001");
    idle_check(1, 2, "b0001_post");
    set_cmd(1, 4'b1110);
    send_pulse(1);
    packet_body(1, 4'b1110, 1'b0, "b1110");

    // Re-request and command change mid-packet must not alter or extend it
    set_cmd(0, 4'b0101);
    send_pulse(0);
    packet_body(0, 4'b0101, 1'b1, "a_dist");
    idle_check(0, 3, "a_dist_post");

    // Request on the first IDLE cycle starts the next packet immediately
    set_cmd(0, 4'b1010);
    send_pulse(0);
    packet_body(0, 4'b1010, 1'b0, "a_b2b1");
    set_cmd(0, 4'b0011);
    send_pulse(0);
    packet_body(0, 4'b0011, 1'b0, "a_b2b2");
    idle_check(0, 2, "a_b2b_post");

    // Reset in the LEFT burst, with a simultaneous request that reset must win over
    set_cmd(0, 4'b0110);
    send_pulse(0);
    repeat (25) step();
    check_eq("a_left_busy", 32'(get_busy(0)), 32'd1);
    RESET = 1'b1;
    set_send(0, 1'b1);
    step();
    check_eq("a_rst_busy", 32'(get_busy(0)), 32'd0);
    check_eq("a_rst_led", 32'(get_led(0)), 32'd0);
    RESET = 1'b0;
    set_send(0, 1'b0);
    step();
    idle_check(0, 2, "a_rst_idle");
    set_cmd(0, 4'b1001);
    send_pulse(0);
    packet_body(0, 4'b1001, 1'b0, "a_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
